// File: rtl/instr_encoder.sv
// instr_encoder
//   Builds RV32I instruction words (add/sub/and/or/slt, addi-family, lw, sw,
//   beq) from assembled instruction fields. Each legal word is tagged with a
//   sequential word address so that it can be loaded into instruction memory.
//   There is one registered output stage, with valid/ready on both sides.
//
// Ports
//   clk, rst_n      clock and asynchronous active-low reset
//   clr             synchronous clear: counter to BASE_ADDR, pending output dropped
//   in_valid/ready  input handshake
//   in_kind         000 R, 001 lw, 010 addi-family, 011 sw, 100 beq
//   in_alu          000 add, 001 sub, 010 and, 011 or, 101 slt
//   in_rd/rs1/rs2   register indices
//   in_imm          signed immediate (byte offset for beq)
//   out_valid/ready output handshake
//   out_instr       encoded instruction word
//   out_addr        word address of out_instr
//   err             one-cycle pulse after an illegal item is accepted
module instr_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_alu,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    KIND_R    = 3'b000,
    KIND_LW   = 3'b001,
    KIND_ADDI = 3'b010,
    KIND_SW   = 3'b011,
    KIND_BEQ  = 3'b100
  } kind_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_e;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [ADDR_W-1:0] cnt_q,       cnt_d;
  logic              err_q,       err_d;

  logic        accept;
  logic        legal;
  logic [31:0] enc;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        alu_ok;
  logic        imm_i_ok;
  logic        imm_b_ok;

  assign in_ready  = !clr && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;

  // Range checks in sign-extension form: -2048..2047 means bits [31:11] are
  // all equal. -4096..4094 even means bits [31:12] are all equal and bit 0 is 0.
  always_comb begin
    imm_i_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
    imm_b_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
  end

  always_comb begin
    funct3 = 3'b000;
    funct7 = 7'b0000000;
    alu_ok = 1'b1;
    case (in_alu)
      ALU_ADD: funct3 = 3'b000;
      ALU_SUB: begin
        funct3 = 3'b000;
        funct7 = 7'b0100000;
      end
      ALU_AND: funct3 = 3'b111;
      ALU_OR:  funct3 = 3'b110;
      ALU_SLT: funct3 = 3'b010;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    enc   = '0;
    case (in_kind)
      KIND_R: begin
        legal = alu_ok;
        enc   = {funct7, in_rs2, in_rs1, funct3, in_rd, 7'b0110011};
      end
      KIND_LW: begin
        legal = imm_i_ok;
        enc   = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      end
      KIND_ADDI: begin
        legal = alu_ok && (in_alu != ALU_SUB) && imm_i_ok;
        enc   = {in_imm[11:0], in_rs1, funct3, in_rd, 7'b0010011};
      end
      KIND_SW: begin
        legal = imm_i_ok;
        enc   = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      end
      KIND_BEQ: begin
        legal = imm_b_ok;
        enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                 in_imm[4:1], in_imm[11], 7'b1100011};
      end
      default: legal = 1'b0;
    endcase
  end

  // A retire and a new load may coincide; the load wins so there is no bubble.
  // Illegal items still complete the handshake but leave the held word alone.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    if (clr) begin
      cnt_d       = BASE;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        if (legal) begin
          out_valid_d = 1'b1;
          out_instr_d = enc;
          out_addr_d  = cnt_q;
          cnt_d       = cnt_q + 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= BASE;
      cnt_q       <= BASE;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

endmodule
